muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative multi-cycle multiply/divide responder that owns the HI/LO register pair.
- The ALU issues MULT/MULTU/DIV/DIVU to it through a start/busy/done handshake.
- MFHI/MFLO read hi/lo directly; MTHI/MTLO write them through hi_we/lo_we.
- Radix-2 shift-add multiply and restoring divide, one bit per clock.

Parameters:
WIDTH, 32, operand width and width of each of hi and lo.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted when start && !busy && !flush
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
in_s1  input  WIDTH  multiplicand / dividend, sampled on accept
in_s2  input  WIDTH  multiplier / divisor, sampled on accept
flush  input  1  cancels the in-flight operation
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in flight
done  output  1  one-cycle pulse; hi/lo hold the new result
div_by_zero  output  1  set with done for a divide with in_s2==0; held until next accept
hi  output  WIDTH  product high half / remainder
lo  output  WIDTH  product low half / quotient

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Assertion mid-operation discards the operation; no done follows.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on accept (edge E0). Operands are latched and the counter loaded with WIDTH.
  - RUN iterates one bit per edge for WIDTH edges (E1..E_WIDTH), then goes to FIX.
  - FIX applies the sign fixup and writes hi/lo at edge E_WIDTH+1, then returns to IDLE.
- Timing: done=1 and busy=0 for exactly the cycle after E_WIDTH+1, i.e. WIDTH+1 cycles after accept. Latency is fixed for all ops, including divide by zero.
- Back-to-back: a start in the done cycle is accepted.
- busy: 1 from the cycle after E0 through the FIX cycle inclusive.
- Multiply: 2*WIDTH-bit product; hi=product[2W-1:W], lo=product[W-1:0].
- Divide: lo=quotient, hi=remainder.
  - in_s2==0: no special-casing in the datapath; the restoring algorithm yields lo=all ones, hi=dividend. div_by_zero=1. Sign fixup is bypassed.
- start while busy: ignored; no queueing.
- flush:
  - While busy: return to IDLE next edge, busy=0, no done; hi/lo keep their pre-operation values.
  - While idle: no effect, and it blocks acceptance of a same-cycle start.
- hi_we/lo_we: write hi/lo from wdata at the edge when !busy; ignored while busy.
  - A write in the accept cycle takes effect, and the later result overwrites it.
  - hi_we and lo_we together write both registers.
- Intermediate accumulators are internal; hi/lo change only at FIX edges, MT writes, or reset.

Optional Feature:
MULDIV_SIGNED_EN.
- Defined:
  - op[0]=1 selects signed operation: absolute values of the operands enter the datapath, and FIX negates the results.
  - Product is negated if the operand signs differ; quotient is negated if the signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Undefined: op[0] is ignored, all ops are unsigned, and FIX is a pass-through cycle, so latency is unchanged.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding constants MULDIV_MULTU/MULT/DIVU/DIV;
  - state enum (IDLE, RUN, FIX);
  - default WIDTH constant.
- One sub-module, muldiv_sign_fix: combinational abs-on-entry and negate-on-exit. It is instantiated only under MULDIV_SIGNED_EN.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001, busy=0 in the done cycle.
2. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002, div_by_zero=0. Then an immediate DIVU 5/0 accepted in the done cycle -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1.
3. MULT -3*5:
   - with macro -> hi=0xFFFFFFFF, lo=0xFFFFFFF1;
   - without macro -> hi=0x00000004, lo=0xFFFFFFF1.
4. DIV -7/2 with macro -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
5. MTLO 0x1234 idle; start MULTU; start again at cycle 5 (ignored); flush at cycle 10 -> busy=0 at cycle 11, no done, lo=0x1234. An MTHI while busy is ignored.
6. rst_n low at cycle 20 of a DIVU -> hi=lo=0, busy=done=0 immediately; no done pulse after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states, default width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] MULDIV_MULTU = 2'b00;
  localparam logic [1:0] MULDIV_MULT  = 2'b01;
  localparam logic [1:0] MULDIV_DIVU  = 2'b10;
  localparam logic [1:0] MULDIV_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Signed-operation helper: absolute values on entry, result negation on exit.
// The module only exists when MULDIV_SIGNED_EN is defined.
`ifdef MULDIV_SIGNED_EN
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             signed_op,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] abs1,
  output logic [WIDTH-1:0] abs2,
  input  logic             is_div,
  input  logic             div_zero,
  input  logic             a_neg,
  input  logic             b_neg,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign abs1     = (signed_op && s1[WIDTH-1]) ? -s1 : s1;
  assign abs2     = (signed_op && s2[WIDTH-1]) ? -s2 : s2;
  assign prod     = {res_hi, res_lo};
  assign prod_neg = -prod;

  // Remainder follows the dividend's sign; a zero divisor leaves the raw result untouched.
  always_comb begin
    fix_hi = res_hi;
    fix_lo = res_lo;
    if (!is_div) begin
      if (a_neg ^ b_neg) {fix_hi, fix_lo} = prod_neg;
    end else if (!div_zero) begin
      if (a_neg ^ b_neg) fix_lo = -res_lo;
      if (a_neg)         fix_hi = -res_hi;
    end
  end

endmodule
`endif

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO pair.
// MULDIV_SIGNED_EN enables signed MULT/DIV via muldiv_sign_fix; otherwise all ops are unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_s1,
  input  logic [WIDTH-1:0] in_s2,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: a request is taken on a rising edge where start && !busy && !flush;
  // done pulses for one cycle with busy low, and a new start in that cycle is taken.
  muldiv_state_e    state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             is_div, b_zero;
  logic             accept;
  logic [WIDTH-1:0] abs1, abs2, fix_hi, fix_lo;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   add_sum, trial;

  assign busy      = (state != ST_IDLE);
  assign accept    = start && !busy && !flush;
  assign dbg_state = state;

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_op (op[0]),
    .s1        (in_s1),
    .s2        (in_s2),
    .abs1      (abs1),
    .abs2      (abs2),
    .is_div    (is_div),
    .div_zero  (b_zero),
    .a_neg     (a_neg),
    .b_neg     (b_neg),
    .res_hi    (acc_hi),
    .res_lo    (acc_lo),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_neg <= 1'b0;
      b_neg <= 1'b0;
    end else if (accept) begin
      a_neg <= op[0] && in_s1[WIDTH-1];
      b_neg <= op[0] && in_s2[WIDTH-1];
    end
  end
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign abs1       = in_s1;
  assign abs2       = in_s2;
  assign fix_hi     = acc_hi;
  assign fix_lo     = acc_lo;
`endif

  assign add_sum = {1'b0, acc_hi} + {1'b0, opb};
  assign trial   = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};

  // One step: shift-add for multiply, shift-subtract-restore for divide.
  always_comb begin
    hi_n = acc_hi;
    lo_n = acc_lo;
    if (!is_div) begin
      if (acc_lo[0]) begin
        hi_n = add_sum[WIDTH:1];
        lo_n = {add_sum[0], acc_lo[WIDTH-1:1]};
      end else begin
        hi_n = {1'b0, acc_hi[WIDTH-1:1]};
        lo_n = {acc_hi[0], acc_lo[WIDTH-1:1]};
      end
    end else begin
      if (!trial[WIDTH]) begin
        hi_n = trial[WIDTH-1:0];
        lo_n = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        lo_n = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      is_div      <= 1'b0;
      b_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hi_we && !busy) hi <= wdata;
      if (lo_we && !busy) lo <= wdata;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_RUN;
            cnt         <= CW'(WIDTH);
            acc_hi      <= '0;
            acc_lo      <= abs1;
            opb         <= abs2;
            is_div      <= op[1];
            b_zero      <= (in_s2 == '0);
            div_by_zero <= 1'b0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= is_div && b_zero;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
